// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage and imem.
// master = fetch (issues requests), slave = imem (accepts, returns data).
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC owner, DEPTH-entry prefetch buffer, redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetch.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master imem,
    output logic          instr_valid,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          fetch_misaligned
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   buf_data [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count_left;
    logic [CW-1:0] pend;
    logic [CW:0]   occupancy;
    logic [31:0]   target;
    logic          bad_target;
    logic          issue;
    logic          accept;
    logic          rsp;
    logic          keep;
    logic          pop;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target     = redirect_pc;
    assign bad_target = |redirect_pc[1:0];
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign target          = {redirect_pc[31:2], 2'b00};
    assign bad_target      = 1'b0;
`endif

    // Slots freed by this cycle's pop count as credit so a drained
    // buffer refills without a bubble.
    assign pop        = instr_valid & instr_ready;
    assign count_left = count - CW'(pop);
    assign occupancy  = {1'b0, count_left} + {1'b0, outstanding};

    assign issue  = (state == RUN) && !redirect
                  && (occupancy < {1'b0, FULL});
    assign accept = issue & imem.imem_ready;

    // A response with nothing outstanding is a leftover from before reset.
    assign rsp  = imem.imem_rvalid && (outstanding != '0);
    assign keep = rsp && (discard == '0) && !redirect;
    assign pend = outstanding - CW'(rsp);

    assign imem.imem_req  = issue;
    assign imem.imem_addr = fetch_pc;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? buf_data[rd_ptr] : NOP;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr] : resp_pc;

    always_comb begin
        state_nxt = state;
        if (redirect)
            state_nxt = bad_target ? HALT : RUN;
        else if (state == BOOT)
            state_nxt = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= BOOT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= (pend > FULL) ? FULL : pend;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (keep)
                    resp_pc <= resp_pc + 32'd4;
                if (rsp && (discard != '0))
                    discard <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (keep)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (keep) begin
            buf_data[wr_ptr] <= imem.imem_rdata;
            buf_pc[wr_ptr]   <= resp_pc;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misaligned <= 1'b0;
        else if (redirect)
            misaligned <= bad_target;
    end

    assign fetch_misaligned = misaligned;
`else
    assign fetch_misaligned = 1'b0;
`endif

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(keep && (count == FULL))
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: in-order imem model with random
// latency, and a PC-stream reference for the delivered instructions.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_misaligned;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem            (bus),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // imem content: every address holds a distinct word
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    int          p_ready = 100, p_iready = 100, p_redir = 0;
    int          stray_cycles = 0;
    logic [31:0] exp_pc, exp_fetch;
    bit          halted = 1'b0;
    int          delivered = 0;
    int          valid_cycles = 0;
    logic [31:0] first_pc = 32'hFFFF_FFFF;
    bit          want_first = 1'b1;
    bit          boot_cycle = 1'b0;
    logic        last_req, last_rvalid, last_pop;

    task automatic cycle(input bit do_redir, input logic [31:0] tgt);
        int d;
        @(negedge clk);
        rst_n       = 1'b1;
        redirect    = do_redir;
        redirect_pc = tgt;
        if (!do_redir && p_redir != 0
            && int'($urandom_range(99)) < p_redir) begin
            redirect    = 1'b1;
            redirect_pc = {20'h0, 10'($urandom_range(1023)), 2'b00};
            if ($urandom_range(7) == 0)
                redirect_pc[1:0] = 2'($urandom_range(3));
            if ($urandom_range(15) == 0)
                redirect_pc = 32'hFFFF_FFF0;
        end
        instr_ready     = int'($urandom_range(99)) < p_iready;
        bus.imem_ready  = int'($urandom_range(99)) < p_ready;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word_at(mq_addr[0]);
        end else if (stray_cycles > 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        if (stray_cycles > 0)
            stray_cycles--;
        #1;
        last_req    = bus.imem_req;
        last_rvalid = bus.imem_rvalid;
        last_pop    = instr_valid & instr_ready;
        if (boot_cycle)
            check("boot_no_req", 32'(bus.imem_req), 32'd0);
        boot_cycle = 1'b0;
        if (redirect)
            check("req_in_redirect", 32'(bus.imem_req), 32'd0);
        check("misaligned_flag", 32'(fetch_misaligned), 32'(halted));
        if (halted) begin
            check("halt_req", 32'(bus.imem_req), 32'd0);
            check("halt_valid", 32'(instr_valid), 32'd0);
        end
        if (instr_valid) begin
            valid_cycles++;
            if (want_first) begin
                first_pc   = instr_pc;
                want_first = 1'b0;
            end
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, word_at(exp_pc));
            if (instr_ready) begin
                exp_pc += 32'd4;
                delivered++;
            end
        end
        if (bus.imem_req && bus.imem_ready) begin
            check("imem_addr", bus.imem_addr, exp_fetch);
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (mq_due.size() != 0 && d < mq_due[$])
                d = mq_due[$];
            mq_addr.push_back(bus.imem_addr);
            mq_due.push_back(d);
            exp_fetch += 32'd4;
        end
        if (bus.imem_rvalid && mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        check("inflight_bound", 32'(mq_addr.size() <= DEPTH), 32'd1);
        if (redirect) begin
            want_first = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            halted    = (redirect_pc[1:0] != 2'b00);
            exp_pc    = redirect_pc;
            exp_fetch = redirect_pc;
`else
            exp_pc    = {redirect_pc[31:2], 2'b00};
            exp_fetch = {redirect_pc[31:2], 2'b00};
`endif
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        instr_ready     = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_pc", instr_pc, RESET_PC);
        check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
        mq_addr.delete();
        mq_due.delete();
        exp_pc       = RESET_PC;
        exp_fetch    = RESET_PC;
        halted       = 1'b0;
        want_first   = 1'b1;
        valid_cycles = 0;
        boot_cycle   = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0;
        rst_n           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        instr_ready     = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        // fill and sustained throughput with 1-cycle imem
        do_reset();
        repeat (14) cycle(1'b0, '0);
        check("throughput", valid_cycles, 32'd11);
        check("first_pc_boot", first_pc, RESET_PC);

        // decode stall: requests must stop once the buffer is committed
        p_iready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0);
            if (i >= 1)
                check("stall_req", 32'(last_req), 32'd0);
        end
        p_iready = 100;
        repeat (6) cycle(1'b0, '0);

        // redirect with two words in flight
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 20 && mq_addr.size() != 2; i++)
            cycle(1'b0, '0);
        check("two_inflight", mq_addr.size(), 32'd2);
        cycle(1'b1, 32'h100);
        repeat (10) cycle(1'b0, '0);
        check("redir_first_pc", first_pc, 32'h100);

        // redirect coinciding with a response and a pop
        lat_min = 1;
        lat_max = 1;
        repeat (6) cycle(1'b0, '0);
        cycle(1'b1, 32'h200);
        check("redir_rsp_pop", 32'({last_rvalid, last_pop}), 32'd3);
        repeat (6) cycle(1'b0, '0);
        check("redir2_first_pc", first_pc, 32'h200);

        // misaligned target
        cycle(1'b1, 32'h102);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0);
`ifdef FETCH_ALIGN_CHECK_EN
            check("halt_flag", 32'(fetch_misaligned), 32'd1);
`endif
        end
`ifndef FETCH_ALIGN_CHECK_EN
        check("unaligned_first_pc", first_pc, 32'h100);
`endif
        cycle(1'b1, 32'h200);
        repeat (6) cycle(1'b0, '0);
        check("realign_first_pc", first_pc, 32'h200);
        check("realign_flag", 32'(fetch_misaligned), 32'd0);

        // address wrap
        cycle(1'b1, 32'hFFFF_FFF8);
        repeat (8) cycle(1'b0, '0);
        check("wrap_first_pc", first_pc, 32'hFFFF_FFF8);

        // random traffic
        p_ready  = 70;
        p_iready = 70;
        p_redir  = 3;
        lat_min  = 1;
        lat_max  = 4;
        d0       = delivered;
        repeat (3000) cycle(1'b0, '0);
        check("rand_progress", 32'((delivered - d0) >= 200), 32'd1);

        // reset mid-stream with one request outstanding
        p_ready  = 100;
        p_iready = 100;
        p_redir  = 0;
        lat_min  = 3;
        lat_max  = 3;
        do_reset();
        repeat (2) cycle(1'b0, '0);
        check("one_inflight", mq_addr.size(), 32'd1);
        do_reset();
        stray_cycles = 2;
        lat_min      = 1;
        lat_max      = 1;
        repeat (8) cycle(1'b0, '0);
        check("post_rst_first_pc", first_pc, RESET_PC);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Producer end of the instruction interface: owns the PC, issues word fetches to instruction memory and delivers `instr`/`instr_pc` to the control decoder.
- Buffers up to DEPTH fetched words so imem latency and decode stalls are decoupled.
- Accepts redirects from the branch/jump resolution logic (branch, jump, jump_reg paths). A redirect flushes buffered and in-flight words and restarts fetch at the new target.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, prefetch buffer entries; also the max outstanding imem requests. Legal values: power of 2, 2..8.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request valid
- imem_addr  output  32  word-aligned fetch address
- imem_ready  input  1  imem accepts request this cycle (handshake = imem_req & imem_ready)
- imem_rvalid  input  1  read data valid; responses in request order, ≥1 cycle after accept
- imem_rdata  input  32  instruction word
- instr_valid  output  1  instr/instr_pc valid to decode
- instr  output  32  instruction to control decoder
- instr_pc  output  32  PC of instr
- instr_ready  input  1  decode consumes instr this cycle
- redirect  input  1  taken branch/jump/jalr
- redirect_pc  input  32  target PC
- fetch_misaligned  output  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=BOOT, fetch_pc=RESET_PC, buffer empty, outstanding=0, discard=0.
  - Outputs during reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, fetch_misaligned=0.
  - Reset asserted mid-operation drops all buffered and in-flight words. Responses arriving after reset release with no live request are ignored (outstanding=0).
- FSM states:
  - BOOT: one cycle after reset release, no request; then RUN.
  - RUN: normal fetch.
  - HALT: only entered with the optional feature. Leaves only on an aligned redirect (→RUN) or reset.
- Issue rule (RUN): imem_req=1 iff (count + outstanding) < DEPTH and redirect=0. imem_addr=fetch_pc.
  - On accept: fetch_pc += 4 (wraps 32'hFFFF_FFFC→0) and outstanding+1.
- Response rule: on imem_rvalid, outstanding−1.
  - If discard>0: drop the word, discard−1.
  - Else: push {imem_rdata, pc_of_word} into buffer. The PC is tracked by a separate resp_pc counter advanced on each kept word.
- Output: instr_valid = buffer non-empty. instr/instr_pc = head entry, combinational from buffer (zero extra latency). Pop on instr_valid & instr_ready.
- Latency: first instr_valid no earlier than 2 cycles after the first accept with 1-cycle imem. Back-to-back sustained throughput is 1 instr/cycle when imem latency ≤ DEPTH−1.
- Redirect (highest priority, single cycle):
  - Buffer flushed (instr_valid=0 next cycle).
  - discard = outstanding, minus 1 if a response is in the same cycle (that response is itself dropped).
  - fetch_pc=resp_pc=redirect_pc. No request issued in the redirect cycle.
- Simultaneous events:
  - Pop and push in same cycle: count unchanged.
  - Push into full buffer cannot occur (guaranteed by issue rule); assertion checks this.
  - Redirect with instr_ready=1: the head is considered consumed by decode; flush still applies.
- Widths: count and outstanding are $clog2(DEPTH)+1 bits. discard saturates at DEPTH.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: redirect with redirect_pc[1:0]≠0 → flush as normal, state=HALT, fetch_misaligned=1 (sticky), no requests. An aligned redirect clears the flag and returns to RUN.
- Not defined: redirect_pc[1:0] is forced to 2'b00, HALT is unreachable, and fetch_misaligned is tied 0.

Test Plan:
- Reset release, imem 1-cycle latency, instr_ready=1 → first accepted imem_addr=0x0, then 0x4, 0x8; instr_pc 0x0,0x4,0x8 on consecutive cycles, no bubbles after fill.
- instr_ready=0 for 5 cycles → at most DEPTH=2 outstanding+buffered, imem_req drops to 0; on release, words 0x0,0x4 delivered in order, fetch resumes at 0x8.
- Redirect to 0x100 with 2 in-flight responses → both responses dropped, next instr_pc=0x100, no stale word ever has instr_valid=1.
- Redirect in the same cycle as imem_rvalid and a pop → response dropped, discard=1 for the remaining in-flight word, next delivered instr_pc=redirect_pc.
- rst_n pulsed low mid-stream with 1 outstanding → outputs immediately at reset values; late rvalid after release ignored; fetch restarts at RESET_PC.
- With FETCH_ALIGN_CHECK_EN: redirect to 0x102 → fetch_misaligned=1, imem_req=0 held; redirect to 0x200 clears the flag and delivers instr_pc=0x200. Without the macro: same stimulus fetches from 0x100.
